// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial-input, configuration and match-status bundle
// for seq_detector_param. The match counter signals (match_cnt, cnt_clr)
// exist only when MATCH_CNT_EN is defined.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int CNT_W   = 16
);
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               out;
    logic [LEN_W-1:0]   present;
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_clr;
`endif

    // Stream/config source side.
    modport master (
`ifdef MATCH_CNT_EN
        output cnt_clr,
        input  match_cnt,
`endif
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  out, present
    );

    // Detector side.
    modport slave (
`ifdef MATCH_CNT_EN
        input  cnt_clr,
        output match_cnt,
`endif
        input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output out, present
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-pattern detector.
// The last received bit sits in hist[0]; a match compares the low len bits
// of the shifted history against the low len bits of the pattern.
// Optional feature macro: MATCH_CNT_EN adds a saturating match counter
// (match_cnt) with a synchronous clear (cnt_clr).
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    seq_detector_param_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    // Reject configurations the datapath cannot represent.
    if (MAX_LEN < 2 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: MAX_LEN must be >= 2 and CNT_W >= 1");
    end

    // Length 0 stays 0 (detector disabled); anything above MAX_LEN clamps.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l > LEN_MAX) begin
            return LEN_MAX;
        end
        return l;
    endfunction

    // Mask selecting the low l history/pattern bits.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (LEN_W'(i) < l);
        end
        return m;
    endfunction

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               out_q, out_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               hit;

    // Candidate history/fill after accepting the current bit, and the match test on it.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], bus.x};
        fill_inc   = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + 1'b1;
        hit        = bus.x_valid && !bus.cfg_load && (len_q != '0) &&
                     (fill_inc >= len_q) &&
                     (((hist_shift ^ pat_q) & len_mask(len_q)) == '0);
    end

    // Next state: cfg_load wins over a coincident bit; non-overlap restarts after a hit.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        out_d  = 1'b0;
        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pattern;
            len_d  = clamp_len(bus.cfg_len);
            ovl_d  = bus.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.x_valid) begin
            out_d = hit;
            if (hit && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
            end
        end
    end

    // State register; reset returns config to pattern 0, full length, overlap on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            pat_q  <= '0;
            len_q  <= LEN_MAX;
            ovl_q  <= 1'b1;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.out     = out_q;
        bus.present = fill_q;
    end

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of hits; clear beats a coincident hit.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter output.
    always_comb begin
        bus.match_cnt = cnt_q;
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (MAX_LEN=8). Counter checks are
// compiled in only when MATCH_CNT_EN is defined.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_W   = 2;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given serial input; returns 1 time unit after the edge.
    task automatic tick(input logic xv, input logic xb);
        bus.x_valid = xv;
        bus.x       = xb;
        @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
        bus.x       = 1'b0;
    endtask

    task automatic load(input logic [7:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic xv);
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        bus.cfg_load    = 1'b1;
        bus.x_valid     = xv;
        bus.x           = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_load    = 1'b0;
        bus.x_valid     = 1'b0;
        bus.x           = 1'b0;
    endtask

    // Feed n bits (MSB of the low n bits first) and check out after each.
    task automatic feed(input string tag, input logic [15:0] bits, input int n,
                        input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            tick(1'b1, bits[i]);
            chk($sformatf("%s_b%0d", tag, n - i), {31'd0, bus.out}, {31'd0, exp[i]});
        end
    endtask

    initial begin
        logic [7:0] sbits;
        logic [7:0] sexp;
        reset           = 1'b1;
        bus.x           = 1'b0;
        bus.x_valid     = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
`ifdef MATCH_CNT_EN
        bus.cnt_clr     = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out", {31'd0, bus.out}, 32'd0);
        chk("rst_present", {28'd0, bus.present}, 32'd0);
        reset = 1'b0;

        // Reset config: pattern 0, len 8 -> eight zeros match on the 8th bit.
        feed("rstcfg", 16'h0000, 8, 16'h0001);
        chk("rstcfg_present", {28'd0, bus.present}, 32'd8);

        // Overlap on, 11011 in 11011011: pulses after bits 5 and 8.
        load(8'b11011, 4'd5, 1'b1, 1'b0);
        chk("ov1_load_present", {28'd0, bus.present}, 32'd0);
        feed("ov1a", 16'b11011, 5, 16'b00001);
        chk("ov1_present5", {28'd0, bus.present}, 32'd5);
        feed("ov1b", 16'b011, 3, 16'b001);
        chk("ov1_present8", {28'd0, bus.present}, 32'd8);

        // Overlap off: only the first pulse, history restarts.
        load(8'b11011, 4'd5, 1'b0, 1'b0);
        feed("ov0a", 16'b11011, 5, 16'b00001);
        chk("ov0_present5", {28'd0, bus.present}, 32'd0);
        feed("ov0b", 16'b011, 3, 16'b000);
        chk("ov0_present8", {28'd0, bus.present}, 32'd3);

        // Idle gaps of 3 cycles after every bit do not disturb detection.
        load(8'b11011, 4'd5, 1'b1, 1'b0);
        sbits = 8'b11011011;
        sexp  = 8'b00001001;
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1, sbits[i]);
            chk($sformatf("gap_b%0d", 8 - i), {31'd0, bus.out}, {31'd0, sexp[i]});
            for (int g = 0; g < 3; g++) begin
                tick(1'b0, 1'b1);
                chk($sformatf("gap_b%0d_idle%0d", 8 - i, g), {31'd0, bus.out}, 32'd0);
            end
            chk($sformatf("gap_b%0d_present", 8 - i), {28'd0, bus.present}, 32'(8 - i));
        end

        // Asynchronous reset mid-stream.
        load(8'b11011, 4'd5, 1'b1, 1'b0);
        feed("pre_rst", 16'b1101, 4, 16'b0000);
        chk("pre_rst_present", {28'd0, bus.present}, 32'd4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out", {31'd0, bus.out}, 32'd0);
        chk("async_rst_present", {28'd0, bus.present}, 32'd0);
        #1 reset = 1'b0;
        feed("post_rst", 16'b1, 1, 16'b0);
        chk("post_rst_present", {28'd0, bus.present}, 32'd1);
        load(8'b11011, 4'd5, 1'b1, 1'b0);
        feed("reload", 16'b11011, 5, 16'b00001);

        // len 0 disables detection; coincident bit on cfg_load is dropped.
        load(8'hFF, 4'd0, 1'b1, 1'b1);
        chk("len0_drop_present", {28'd0, bus.present}, 32'd0);
        feed("len0", 16'h03FF, 10, 16'h0000);
        chk("len0_present_sat", {28'd0, bus.present}, 32'd8);

        // len 12 clamps to 8; 0xA5 detected after 8 bits.
        load(8'hA5, 4'd12, 1'b1, 1'b0);
        feed("clampA5", 16'hA5, 8, 16'h01);

        // Periodic pattern 11: back-to-back pulses with overlap, alternate without.
        load(8'b11, 4'd2, 1'b1, 1'b0);
        feed("b2b_ov1", 16'b111, 3, 16'b011);
        load(8'b11, 4'd2, 1'b0, 1'b0);
        feed("b2b_ov0", 16'b1111, 4, 16'b0101);

`ifdef MATCH_CNT_EN
        // Counter saturates at 3 (CNT_W=2); clear beats a coincident hit.
        load(8'h01, 4'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1, 1'b1);
            chk($sformatf("cnt_out%0d", k), {31'd0, bus.out}, 32'd1);
            chk($sformatf("cnt_val%0d", k), {30'd0, bus.match_cnt}, (k < 3) ? 32'(k) : 32'd3);
        end
        bus.cnt_clr = 1'b1;
        tick(1'b1, 1'b1);
        bus.cnt_clr = 1'b0;
        chk("cnt_clr_out", {31'd0, bus.out}, 32'd1);
        chk("cnt_clr_val", {30'd0, bus.match_cnt}, 32'd0);
        tick(1'b1, 1'b1);
        chk("cnt_after_clr", {30'd0, bus.match_cnt}, 32'd1);
        load(8'h00, 4'd3, 1'b1, 1'b0);
        chk("cnt_cfg_load", {30'd0, bus.match_cnt}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 5-bit Moore detector.
- Pattern, pattern length and overlap mode are runtime-programmable. Pattern length can be up to MAX_LEN bits.
- Serial input is gated by a valid strobe.
- Sits on a serial data path; the registered match pulse feeds downstream framing/alignment logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN)+1, width of the length field.
- CNT_W, 16, width of the match counter (optional feature only).

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only when high.
- cfg_load  input  1  1-cycle strobe; captures cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit 0 = last bit received; only bits [len-1:0] are used.
- cfg_len  input  LEN_W  pattern length, 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- out  output  1  registered match pulse.
- present  output  LEN_W  current fill count (bits of history held), 0..MAX_LEN.
- match_cnt  output  CNT_W  saturating match count (only with MATCH_CNT_EN).
- cnt_clr  input  1  synchronous clear of match_cnt (only with MATCH_CNT_EN).

Behaviour:
- Reset (async, immediate):
  - hist=0, fill=0, out=0.
  - pattern=0, len=MAX_LEN, overlap=1.
  - match_cnt=0.
- State:
  - hist: MAX_LEN-bit shift register.
  - fill: saturates at MAX_LEN; drives present.
  - cfg registers: pattern, len, overlap.
- Length clamping at capture: cfg_len=0 → len=0, which means detection disabled (out never asserts). cfg_len>MAX_LEN → clamped to MAX_LEN.
- cfg_load cycle:
  - Capture the config registers.
  - Clear hist and fill to 0; out<=0.
  - A coincident x_valid bit is dropped (cfg_load has priority).
- x_valid=1, no cfg_load:
  - hist_n = {hist[MAX_LEN-2:0], x}
  - fill_n = min(fill+1, MAX_LEN)
  - hit = (len!=0) & (fill_n>=len) & (hist_n[len-1:0]==pattern[len-1:0])
  - out <= hit, i.e. out is high the cycle after the completing bit is sampled, for exactly 1 cycle.
  - If hit and overlap=1: hist<=hist_n, fill<=fill_n, so a suffix can start the next match.
  - If hit and overlap=0: hist<=0, fill<=0, so the next match needs len fresh bits.
  - No hit: hist<=hist_n, fill<=fill_n.
- x_valid=0: hist and fill hold; out<=0. Idle gaps never break a partial match.
- Latency: 1 clk from the sampling edge of the final bit to out high.
- Back-to-back matches are possible in overlap mode when the pattern is periodic; out may be high on consecutive cycles, e.g. pattern 11, len 2, input 111.
- Reset mid-stream: all partial history is lost; config returns to the reset values.

Optional Feature:
- Macro: MATCH_CNT_EN.
- Defined:
  - match_cnt increments on every cycle where out is set (hit).
  - Saturates at all-ones.
  - cnt_clr zeroes it synchronously; cnt_clr takes priority over a coincident hit.
  - Unaffected by cfg_load.
- Undefined:
  - match_cnt and cnt_clr ports are absent.
  - No counter logic is synthesised.

Test Plan:
- Reset, then cfg_load pattern=5'b11011, len=5, overlap=1; feed 1,1,0,1,1,0,1,1 with x_valid=1 → out pulses the cycle after bit 5 and after bit 8; present reads 5 after bit 5.
- Same stream with overlap=0 → out pulses only after bit 5; present=0 after bit 5, 3 after bit 8.
- Overlap=1, pattern=11011: insert x_valid=0 gaps of 3 cycles between every bit → same two pulses, each delayed only by the gaps; out=0 during the gaps.
- Assert reset after bits 1,1,0,1 → out=0, present=0 immediately; feed 1 → no pulse. Reload config, feed 11011 → pulse.
- cfg_len=0 then any stream → out never asserts. cfg_len=12 with MAX_LEN=8 → len clamps to 8; pattern 8'hA5 is detected after 8 bits.
- MATCH_CNT_EN, CNT_W=2: pattern=1, len=1, feed 5 ones → match_cnt saturates at 3. cnt_clr on the same cycle as a hit → match_cnt=0.
